// File: rtl/mem_resp_pkg.sv
// Shared definitions for the memory responder: request size encodings,
// responder state encoding, wait-counter width and the latched request payload.
package mem_resp_pkg;

    localparam int unsigned LAT_W = 4;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } state_e;

    // Request captured at the handshake and held for the whole access.
    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        is_unsigned;
        logic [31:0] wdata;
    } req_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the memory responder (purely combinational).
// Ports:
//   addr_lo      in  2   byte offset within the word
//   size         in  2   access size (SIZE_BYTE/HALF/WORD; RSVD yields zeros)
//   is_unsigned  in  1   zero-extend sub-word loads
//   wdata        in  32  right-justified store data
//   rword        in  32  word read from the array
//   be_c         out 4   store byte enables
//   wdata_rep_c  out 32  store data replicated across lanes
//   rdata_c      out 32  extracted and extended load data
// Half and word accesses ignore the low address bits they cannot use, so a
// misaligned request lands on the enclosing aligned half/word.
module mem_lane_align
    import mem_resp_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be_c,
    output logic [31:0] wdata_rep_c,
    output logic [31:0] rdata_c
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Select the addressed byte and half from the read word.
    always_comb begin
        byte_sel = rword[7:0];
        case (addr_lo)
            2'b00:   byte_sel = rword[7:0];
            2'b01:   byte_sel = rword[15:8];
            2'b10:   byte_sel = rword[23:16];
            default: byte_sel = rword[31:24];
        endcase
        half_sel = addr_lo[1] ? rword[31:16] : rword[15:0];
    end

    // Enables, lane-replicated store data and extended load data per size.
    always_comb begin
        be_c        = 4'b0000;
        wdata_rep_c = 32'h0;
        rdata_c     = 32'h0;
        case (size)
            SIZE_BYTE: begin
                be_c        = 4'b0001 << addr_lo;
                wdata_rep_c = {4{wdata[7:0]}};
                rdata_c     = is_unsigned ? {24'h0, byte_sel}
                                          : {{24{byte_sel[7]}}, byte_sel};
            end
            SIZE_HALF: begin
                be_c        = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_rep_c = {2{wdata[15:0]}};
                rdata_c     = is_unsigned ? {16'h0, half_sel}
                                          : {{16{half_sel[15]}}, half_sel};
            end
            SIZE_WORD: begin
                be_c        = 4'b1111;
                wdata_rep_c = wdata;
                rdata_c     = rword;
            end
            default: begin
                be_c        = 4'b0000;
                wdata_rep_c = 32'h0;
                rdata_c     = 32'h0;
            end
        endcase
    end

endmodule

// File: rtl/mem_responder.sv
// Unified instruction/data memory responder for the multicycle RV32I core.
// Accepts one request at a time, waits LATENCY extra cycles, commits stores
// with byte enables, and returns aligned, extended load data in a one-cycle
// response pulse.
// Parameters: DEPTH_WORDS (power of two, >= 4), LATENCY (0..15).
// Ports:
//   clk, reset (synchronous, active-high)
//   req_valid/req_ready handshake; req_write, req_addr, req_size,
//   req_unsigned, req_wdata request payload
//   rsp_valid pulse with rsp_rdata/rsp_err; busy while ACCESS or RESP
// Optional macro MEM_RESP_MISALIGN_CHECK_EN: reject misaligned half/word
// accesses with rsp_err instead of rounding the address down.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    state_e           state_q, state_d;
    req_t             req_q;
    logic [LAT_W-1:0] cnt_q;
    logic [31:0]      mem [DEPTH_WORDS];

    logic [IDX_W-1:0] idx_c;
    logic             range_err_c;
    logic             size_err_c;
    logic             misalign_err_c;
    logic             err_c;
    logic             accept_c;
    logic             commit_c;
    logic             mem_we_c;
    logic [3:0]       be_c;
    logic [31:0]      wdata_rep_c;
    logic [31:0]      load_c;

    assign idx_c       = req_q.addr[IDX_W+1:2];
    assign range_err_c = (req_q.addr >> (IDX_W + 2)) != 32'h0;
    assign size_err_c  = (req_q.size == SIZE_RSVD);

`ifdef MEM_RESP_MISALIGN_CHECK_EN
    assign misalign_err_c = ((req_q.size == SIZE_HALF) && req_q.addr[0]) ||
                            ((req_q.size == SIZE_WORD) && (req_q.addr[1:0] != 2'b00));
`else
    assign misalign_err_c = 1'b0;
`endif

    assign err_c    = range_err_c | size_err_c | misalign_err_c;
    assign accept_c = (state_q == ST_IDLE) && req_ready && req_valid;
    assign commit_c = (state_q == ST_ACCESS) && (cnt_q == LAT_W'(LATENCY));
    // Reset on the commit edge suppresses the write.
    assign mem_we_c = commit_c && req_q.write && !err_c && !reset;

    mem_lane_align u_align (
        .addr_lo     (req_q.addr[1:0]),
        .size        (req_q.size),
        .is_unsigned (req_q.is_unsigned),
        .wdata       (req_q.wdata),
        .rword       (mem[idx_c]),
        .be_c        (be_c),
        .wdata_rep_c (wdata_rep_c),
        .rdata_c     (load_c)
    );

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept_c) state_d = ST_ACCESS;
            ST_ACCESS: if (commit_c) state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // State, latched request, wait counter and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            req_q     <= '0;
            cnt_q     <= '0;
            req_ready <= 1'b0;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_ready <= (state_d == ST_IDLE);
            busy      <= (state_d != ST_IDLE);
            rsp_valid <= commit_c;

            if (accept_c) begin
                req_q <= '{write:       req_write,
                           addr:        req_addr,
                           size:        req_size,
                           is_unsigned: req_unsigned,
                           wdata:       req_wdata};
                cnt_q <= '0;
            end else if (state_q == ST_ACCESS) begin
                cnt_q <= cnt_q + LAT_W'(1);
            end

            if (commit_c) begin
                rsp_err   <= err_c;
                rsp_rdata <= (err_c || req_q.write) ? 32'h0 : load_c;
            end else if (state_q == ST_RESP) begin
                rsp_err   <= 1'b0;
                rsp_rdata <= 32'h0;
            end
        end
    end

    // Word-organised array; contents are never reset.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (mem_we_c && be_c[b]) begin
                mem[idx_c][8*b +: 8] <= wdata_rep_c[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    localparam int unsigned DEPTH     = 64;
    localparam int unsigned LAT       = 2;
    localparam int unsigned MEM_BYTES = 4 * DEPTH;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  mem_b [MEM_BYTES];
    int          checks = 0;
    int          errors = 0;
    int          rsp_cnt = 0;
    logic [31:0] last_rdata;
    logic        last_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: byte-addressed memory, little-endian access of 1/2/4 bytes.
    function automatic exp_t model(input logic wr, input logic [31:0] addr,
                                   input logic [1:0] size, input logic uns,
                                   input logic [31:0] wd);
        exp_t        e;
        int unsigned nb;
        int unsigned base;
        logic [31:0] v;
        e.rdata = 32'h0;
        e.err   = 1'b0;
        nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        if (size == 2'd3 || addr >= MEM_BYTES) begin
            e.err = 1'b1;
            return e;
        end
`ifdef MEM_RESP_MISALIGN_CHECK_EN
        if ((addr % nb) != 0) begin
            e.err = 1'b1;
            return e;
        end
`endif
        base = addr - (addr % nb);
        if (wr) begin
            for (int i = 0; i < int'(nb); i++) mem_b[base + i] = 8'(wd >> (8 * i));
        end else begin
            v = 32'h0;
            for (int i = 0; i < int'(nb); i++) v = v | (32'(mem_b[base + i]) << (8 * i));
            if (!uns && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
            e.rdata = v;
        end
        return e;
    endfunction

    // Monitor: every response pops the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && rsp_valid) begin
            rsp_cnt++;
            last_rdata = rsp_rdata;
            last_err   = rsp_err;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got rdata 0x%08h err %0b with nothing outstanding at %0t",
                         rsp_rdata, rsp_err, $time);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_err", 32'(rsp_err), 32'(e.err));
            end
        end
    end

    task automatic randomize_idle_inputs();
        req_write    = 1'($urandom);
        req_addr     = $urandom;
        req_size     = 2'($urandom);
        req_unsigned = 1'($urandom);
        req_wdata    = $urandom;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        @(posedge clk); #1;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready) chk("ready_timeout", 32'(req_ready), 32'd1);
    endtask

    // One request with full handshake, timing and busy checks.
    task automatic issue(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input logic [31:0] wd);
        int n;
        wait_ready();
        req_valid    = 1'b1;
        req_write    = wr;
        req_addr     = addr;
        req_size     = size;
        req_unsigned = uns;
        req_wdata    = wd;
        @(posedge clk);
        exp_q.push_back(model(wr, addr, size, uns, wd));
        #1;
        req_valid = 1'b0;
        randomize_idle_inputs();
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (!rsp_valid) begin
                chk("ready_low_access", 32'(req_ready), 32'd0);
                chk("busy_access", 32'(busy), 32'd1);
            end
        end while (!rsp_valid && n < 40);
        chk("rsp_latency", 32'(n), 32'(LAT + 2));
        chk("ready_low_resp", 32'(req_ready), 32'd0);
        chk("busy_resp", 32'(busy), 32'd1);
        @(negedge clk);
        chk("ready_after_resp", 32'(req_ready), 32'd1);
        chk("busy_after_resp", 32'(busy), 32'd0);
        chk("rsp_pulse_width", 32'(rsp_valid), 32'd0);
    endtask

    // Store 0xCAFEF00D to 0x40 and assert reset k cycles into ACCESS.
    task automatic reset_in_access(input int k);
        int cnt0;
        wait_ready();
        req_valid    = 1'b1;
        req_write    = 1'b1;
        req_addr     = 32'h40;
        req_size     = 2'b10;
        req_unsigned = 1'b0;
        req_wdata    = 32'hCAFE_F00D;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int i = 0; i < k; i++) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        cnt0  = rsp_cnt;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        chk("rst_ready_back", 32'(req_ready), 32'd1);
        for (int i = 0; i < int'(LAT) + 4; i++) @(negedge clk);
        chk("rst_no_rsp", 32'(rsp_cnt - cnt0), 32'd0);
        issue(1'b0, 32'h40, 2'b10, 1'b0, 32'h0);
        chk("rst_lw40", last_rdata, 32'h0);
    endtask

    // req_valid held high: one acceptance every LAT+3 cycles.
    task automatic hold_valid_test();
        int acc, cyc, last_acc, cnt0, n;
        acc = 0; cyc = 0; last_acc = -1;
        wait_ready();
        cnt0         = rsp_cnt;
        req_valid    = 1'b1;
        req_write    = 1'b0;
        req_addr     = 32'h10;
        req_size     = 2'b10;
        req_unsigned = 1'b0;
        req_wdata    = 32'h0;
        while ((acc < 6 || req_ready) && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (req_ready) begin
                exp_q.push_back(model(1'b0, 32'h10, 2'b10, 1'b0, 32'h0));
                if (last_acc >= 0) chk("hold_spacing", 32'(cyc - last_acc), 32'(LAT + 3));
                last_acc = cyc;
                acc++;
            end
        end
        req_valid = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("hold_rsp_count", 32'(rsp_cnt - cnt0), 32'(acc));
    endtask

    initial begin
        reset        = 1'b1;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_addr     = 32'h0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_wdata    = 32'h0;
        last_rdata   = 32'h0;
        last_err     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", 32'(req_ready), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rdata", rsp_rdata, 32'h0);
        chk("reset_err", 32'(rsp_err), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_reset", 32'(req_ready), 32'd1);

        // Define every word so the model is complete.
        for (int w = 0; w < int'(DEPTH); w++) issue(1'b1, 32'(4 * w), 2'b10, 1'b0, 32'h0);

        issue(1'b1, 32'h10, 2'b10, 1'b0, 32'hDEAD_BEEF);
        chk("sw_err", 32'(last_err), 32'd0);
        issue(1'b0, 32'h10, 2'b10, 1'b0, 32'h0);
        chk("lw10", last_rdata, 32'hDEAD_BEEF);

        issue(1'b1, 32'h10, 2'b10, 1'b0, 32'h1122_3344);
        issue(1'b1, 32'h13, 2'b00, 1'b0, 32'h0000_0080);
        issue(1'b0, 32'h13, 2'b00, 1'b0, 32'h0);
        chk("lb13", last_rdata, 32'hFFFF_FF80);
        issue(1'b0, 32'h13, 2'b00, 1'b1, 32'h0);
        chk("lbu13", last_rdata, 32'h0000_0080);
        issue(1'b0, 32'h10, 2'b10, 1'b1, 32'h0);
        chk("lw10_after_sb", last_rdata, 32'h8022_3344);

        issue(1'b1, 32'h20, 2'b10, 1'b0, 32'h5566_7788);
        issue(1'b1, 32'h22, 2'b01, 1'b0, 32'h0000_BEEF);
        issue(1'b0, 32'h22, 2'b01, 1'b0, 32'h0);
        chk("lh22", last_rdata, 32'hFFFF_BEEF);
        issue(1'b0, 32'h22, 2'b01, 1'b1, 32'h0);
        chk("lhu22", last_rdata, 32'h0000_BEEF);
        issue(1'b0, 32'h20, 2'b10, 1'b0, 32'h0);
        chk("lw20_after_sh", last_rdata, 32'hBEEF_7788);

        issue(1'b0, 32'h11, 2'b10, 1'b0, 32'h0);
`ifdef MEM_RESP_MISALIGN_CHECK_EN
        chk("lw11_err", 32'(last_err), 32'd1);
        chk("lw11_rdata", last_rdata, 32'h0);
`else
        chk("lw11_err", 32'(last_err), 32'd0);
        chk("lw11_rdata", last_rdata, 32'h8022_3344);
`endif
        issue(1'b1, 32'(MEM_BYTES), 2'b10, 1'b0, 32'h1234_5678);
        chk("sw_range_err", 32'(last_err), 32'd1);
        issue(1'b0, 32'h0, 2'b10, 1'b0, 32'h0);
        chk("lw0_after_range", last_rdata, 32'h0);
        issue(1'b1, 32'h24, 2'b11, 1'b0, 32'hFFFF_FFFF);
        chk("rsvd_err", 32'(last_err), 32'd1);
        issue(1'b0, 32'h24, 2'b10, 1'b0, 32'h0);
        chk("lw24_after_rsvd", last_rdata, 32'h0);

        reset_in_access(0);
        reset_in_access(int'(LAT));

        hold_valid_test();

        for (int i = 0; i < 250; i++) begin
            logic [31:0] a;
            logic [1:0]  s;
            a = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, MEM_BYTES + 15));
            s = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            issue(1'($urandom), a, s, 1'($urandom), $urandom);
        end

        for (int n = 0; n < 50 && exp_q.size() != 0; n++) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
